thread_scheduler: RTL and testbench

- Round-robin hardware-thread scheduler for the barrel fetch stage. It drives the read and write selects, plus the write enable, of the per-thread PC register bank.
- Each cycle it picks one eligible thread to fetch. That thread's PC write-back is either PC+4 or an execute-stage redirect.
- It keeps an in-flight tag pipeline so a thread has at most one instruction in the pipe at any time, which removes intra-thread hazards.

---
 rtl/thread_scheduler_if.sv | 27 ++
 rtl/thread_scheduler.sv | 119 +++++++++++
 tb/tb_thread_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/thread_scheduler_if.sv
// Fetch-stage scheduler bundle: run/stall/redirect controls in, PC bank
// selects and the kill mask out.
interface thread_scheduler_if #(
  parameter int NUM_THREADS = 5,
  parameter int TID_W       = 3,
  parameter int PIPE_DEPTH  = 4
);
  logic [NUM_THREADS-1:0] thread_en;
  logic                   stall;
  logic                   redirect_valid;
  logic [TID_W-1:0]       redirect_tid;
  logic                   fetch_valid;
  logic [TID_W-1:0]       sel_read;
  logic [TID_W-1:0]       sel_write;
  logic                   pc_en;
  logic [PIPE_DEPTH-1:0]  kill_mask;

  modport master (
    output thread_en, stall, redirect_valid, redirect_tid,
    input  fetch_valid, sel_read, sel_write, pc_en, kill_mask
  );

  modport slave (
    input  thread_en, stall, redirect_valid, redirect_tid,
    output fetch_valid, sel_read, sel_write, pc_en, kill_mask
  );
endinterface

// File: rtl/thread_scheduler.sv
// Round-robin barrel-fetch thread scheduler. A tag shift register records
// which thread owns each in-flight slot so a thread never has more than one
// instruction in the pipe. Outputs are combinational from state + inputs.
module thread_scheduler #(
  parameter int NUM_THREADS = 5,
  parameter int TID_W       = 3,
  parameter int PIPE_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  thread_scheduler_if.slave bus
);

  logic [TID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PIPE_DEPTH-1:0]  slot_vld_q, slot_vld_d;
  logic [TID_W-1:0]       slot_tid_q [PIPE_DEPTH];
  logic [TID_W-1:0]       slot_tid_d [PIPE_DEPTH];

  logic [NUM_THREADS-1:0] busy;
  logic [NUM_THREADS-1:0] elig;
  logic [PIPE_DEPTH-1:0]  kill;
  logic                   redir_ok;
  logic                   found;
  logic [TID_W-1:0]       pick;
  logic                   fetch_valid;
  logic [TID_W-1:0]       sel_read;

  // Out-of-range redirect targets are dropped entirely.
  assign redir_ok = bus.redirect_valid && (int'(bus.redirect_tid) < NUM_THREADS);

  // A thread is busy while any valid slot carries its tag.
  always_comb begin
    busy = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        if (slot_vld_q[i] && (slot_tid_q[i] == TID_W'(t))) busy[t] = 1'b1;
      end
    end
  end

  // Eligible: enabled, nothing in flight, and not being redirected right now.
  always_comb begin
    elig = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      elig[t] = bus.thread_en[t] && !busy[t] &&
                !(redir_ok && (bus.redirect_tid == TID_W'(t)));
    end
  end

  // Round-robin search starting just after the last issued thread, ending on it.
  always_comb begin
    logic [TID_W-1:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      idx = TID_W'((int'(rr_ptr_q) + k) % NUM_THREADS);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Slots squashed by this cycle's redirect.
  always_comb begin
    kill = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      kill[i] = redir_ok && slot_vld_q[i] && (slot_tid_q[i] == bus.redirect_tid);
    end
  end

  assign fetch_valid = found && !bus.stall && !reset;
  assign sel_read    = fetch_valid ? pick : '0;

  // PC bank controls; redirect write-back wins over the PC+4 write-back.
  always_comb begin
    bus.fetch_valid = fetch_valid;
    bus.sel_read    = sel_read;
    bus.pc_en       = redir_ok || fetch_valid;
    bus.sel_write   = redir_ok ? bus.redirect_tid : sel_read;
    bus.kill_mask   = kill;
    if (reset) begin
      bus.pc_en     = 1'b0;
      bus.sel_write = '0;
      bus.kill_mask = '0;
    end
  end

  // Next state: shift tags when running, freeze them under stall; kills apply either way.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    slot_vld_d = slot_vld_q & ~kill;
    slot_tid_d = slot_tid_q;
    if (!bus.stall) begin
      slot_vld_d[0] = fetch_valid;
      slot_tid_d[0] = sel_read;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        slot_vld_d[i] = slot_vld_q[i-1] && !kill[i-1];
        slot_tid_d[i] = slot_tid_q[i-1];
      end
      if (fetch_valid) rr_ptr_d = sel_read;
    end
  end

  // State registers; reset parks the pointer on the last thread so thread 0 goes first.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= TID_W'(NUM_THREADS - 1);
      slot_vld_q <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) slot_tid_q[i] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      slot_vld_q <= slot_vld_d;
      slot_tid_q <= slot_tid_d;
    end
  end

endmodule

// File: tb/tb_thread_scheduler.sv
// Bench for thread_scheduler: directed scenarios followed by random traffic,
// every cycle compared against a per-thread occupancy-countdown model.
module tb_thread_scheduler;
  localparam int NUM_THREADS = 5;
  localparam int TID_W       = 3;
  localparam int PIPE_DEPTH  = 4;

  logic clk = 1'b0;
  logic reset;

  thread_scheduler_if #(.NUM_THREADS(NUM_THREADS), .TID_W(TID_W), .PIPE_DEPTH(PIPE_DEPTH)) bus_if ();

  thread_scheduler #(.NUM_THREADS(NUM_THREADS), .TID_W(TID_W), .PIPE_DEPTH(PIPE_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Model: remaining cycles each thread's tag stays in the pipe (0 = free).
  int remain [NUM_THREADS];
  int rr;
  int e_fv, e_rd, e_wr, e_pe, e_km;
  int obs_fv, obs_rd;

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_eval(input logic [NUM_THREADS-1:0] en, input logic st,
                            input logic rv, input logic [TID_W-1:0] rt, input logic rst);
    bit redir;
    bit found;
    int pk;
    redir = rv && (int'(rt) < NUM_THREADS);
    e_fv = 0; e_rd = 0; e_wr = 0; e_pe = 0; e_km = 0;
    if (rst) return;
    found = 0;
    pk = 0;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      int t;
      t = (rr + k) % NUM_THREADS;
      if (!found && en[t] && remain[t] == 0 && !(redir && int'(rt) == t)) begin
        found = 1;
        pk = t;
      end
    end
    e_fv = (found && !st) ? 1 : 0;
    e_rd = e_fv ? pk : 0;
    e_pe = (redir || e_fv) ? 1 : 0;
    e_wr = redir ? int'(rt) : e_rd;
    if (redir && remain[rt] > 0) e_km = 1 << (PIPE_DEPTH - remain[rt]);
  endtask

  task automatic model_edge(input logic st, input logic rv,
                            input logic [TID_W-1:0] rt, input logic rst);
    bit redir;
    redir = rv && (int'(rt) < NUM_THREADS);
    if (rst) begin
      for (int t = 0; t < NUM_THREADS; t++) remain[t] = 0;
      rr = NUM_THREADS - 1;
      return;
    end
    if (redir) remain[rt] = 0;
    if (!st) begin
      for (int t = 0; t < NUM_THREADS; t++) if (remain[t] > 0) remain[t]--;
      if (e_fv != 0) begin
        remain[e_rd] = PIPE_DEPTH;
        rr = e_rd;
      end
    end
  endtask

  // One cycle: drive at negedge, compare just after, advance the model at posedge.
  task automatic step(input logic [NUM_THREADS-1:0] en, input logic st,
                      input logic rv, input logic [TID_W-1:0] rt, input logic rst);
    @(negedge clk);
    bus_if.thread_en      = en;
    bus_if.stall          = st;
    bus_if.redirect_valid = rv;
    bus_if.redirect_tid   = rt;
    reset                 = rst;
    #1;
    model_eval(en, st, rv, rt, rst);
    obs_fv = int'(bus_if.fetch_valid);
    obs_rd = int'(bus_if.sel_read);
    check_val("fetch_valid", obs_fv, e_fv);
    check_val("sel_read",    obs_rd, e_rd);
    check_val("sel_write",   int'(bus_if.sel_write), e_wr);
    check_val("pc_en",       int'(bus_if.pc_en), e_pe);
    check_val("kill_mask",   int'(bus_if.kill_mask), e_km);
    @(posedge clk);
    model_edge(st, rv, rt, rst);
  endtask

  int seq_all [7] = '{0, 1, 2, 3, 4, 0, 1};
  int seq_two [7] = '{0, 1, -1, -1, -1, 0, 1};

  initial begin
    bus_if.thread_en      = '0;
    bus_if.stall          = 1'b0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_tid   = '0;
    reset                 = 1'b1;
    for (int t = 0; t < NUM_THREADS; t++) remain[t] = 0;
    rr = NUM_THREADS - 1;

    step(5'b11111, 1'b0, 1'b0, 3'd0, 1'b1);
    step(5'b11111, 1'b0, 1'b1, 3'd2, 1'b1);

    // All threads enabled: strict rotation from thread 0.
    for (int c = 0; c < 7; c++) begin
      step(5'b11111, 1'b0, 1'b0, 3'd0, 1'b0);
      check_val("seq_all_fv", obs_fv, 1);
      check_val("seq_all_rd", obs_rd, seq_all[c]);
    end

    // Two threads: bubbles while both are in flight.
    step(5'b11111, 1'b0, 1'b0, 3'd0, 1'b1);
    for (int c = 0; c < 7; c++) begin
      step(5'b00011, 1'b0, 1'b0, 3'd0, 1'b0);
      check_val("seq_two_fv", obs_fv, (seq_two[c] >= 0) ? 1 : 0);
      if (seq_two[c] >= 0) check_val("seq_two_rd", obs_rd, seq_two[c]);
    end

    // Redirect of the only running thread frees it for the next cycle.
    step(5'b00100, 1'b0, 1'b0, 3'd0, 1'b1);
    step(5'b00100, 1'b0, 1'b0, 3'd0, 1'b0);
    step(5'b00100, 1'b0, 1'b1, 3'd2, 1'b0);
    check_val("redir_kill_fv", obs_fv, 0);
    step(5'b00100, 1'b0, 1'b0, 3'd0, 1'b0);
    check_val("redir_reissue", obs_fv, 1);

    // Stall mid-stream freezes slots and the pointer.
    step(5'b11111, 1'b0, 1'b0, 3'd0, 1'b1);
    for (int c = 0; c < 2; c++) step(5'b11111, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int c = 0; c < 3; c++) step(5'b11111, 1'b1, 1'b0, 3'd0, 1'b0);
    step(5'b11111, 1'b0, 1'b0, 3'd0, 1'b0);
    check_val("stall_resume", obs_rd, 2);
    for (int c = 0; c < 3; c++) step(5'b11111, 1'b0, 1'b0, 3'd0, 1'b0);

    // Redirect under stall kills thread 1's tag in place.
    step(5'b11111, 1'b0, 1'b0, 3'd0, 1'b1);
    for (int c = 0; c < 2; c++) step(5'b11111, 1'b0, 1'b0, 3'd0, 1'b0);
    step(5'b11111, 1'b1, 1'b1, 3'd1, 1'b0);
    step(5'b11111, 1'b1, 1'b0, 3'd0, 1'b0);
    for (int c = 0; c < 4; c++) step(5'b00010, 1'b0, 1'b0, 3'd0, 1'b0);

    // Out-of-range redirect is ignored; reset mid-stream drops everything.
    for (int c = 0; c < 3; c++) step(5'b11111, 1'b0, 1'b1, 3'd6, 1'b0);
    step(5'b11111, 1'b0, 1'b1, 3'd6, 1'b1);
    step(5'b11111, 1'b0, 1'b0, 3'd0, 1'b0);
    check_val("post_reset_rd", obs_rd, 0);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      logic [NUM_THREADS-1:0] en;
      en = ($urandom_range(0, 3) == 0) ? NUM_THREADS'($urandom) : '1;
      step(en,
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) == 0),
           TID_W'($urandom_range(0, 7)),
           ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
